// File: rtl/tick_prescaler.sv
// tick_prescaler: programmable prescaler producing single-cycle enable pulses
// (tick_o) for a downstream count stage. Period is div_q+1 enabled cycles.
// Modes: continuous or one-shot, selected when a start request is accepted.
// Optional feature macro: TICK_PRESCALER_GATE_EN -- when defined, gate_i is
// synchronised through two flops and counting advances only while it is high.
module tick_prescaler #(
    parameter int WIDTH     = 8,
    parameter int DIV_RESET = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic             load_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             oneshot_i,
    input  logic             gate_i,
    output logic             tick_o,
    output logic             busy_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             cnt_en;

`ifdef TICK_PRESCALER_GATE_EN
    logic gate_meta_q;
    logic gate_sync_q;

    // Two-flop synchroniser bringing the external gate into the clk_i domain
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gate_meta_q <= 1'b0;
            gate_sync_q <= 1'b0;
        end else begin
            gate_meta_q <= gate_i;
            gate_sync_q <= gate_meta_q;
        end
    end

    assign cnt_en = gate_sync_q;
`else
    // Gate input has no function in this build; keep it visibly consumed
    logic unused_gate;
    assign unused_gate = gate_i;
    assign cnt_en      = 1'b1;
`endif

    // Next-state logic; priority is load > stop > start > counting
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        tick_d  = 1'b0;

        if (load_i) begin
            // New divider restarts the period; run/idle state is kept
            div_d = div_i;
            cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (start_i && !stop_i) begin
                        state_d = S_RUN;
                        mode_d  = oneshot_i;
                    end
                end
                S_RUN: begin
                    if (stop_i) begin
                        // Stop suppresses any tick that would fire on this edge
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_en) begin
                        if (cnt_q == div_q) begin
                            tick_d = 1'b1;
                            cnt_d  = '0;
                            if (mode_q) begin
                                state_d = S_IDLE;
                            end
                        end else begin
                            cnt_d = cnt_q + WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, divider, counter and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            div_q   <= WIDTH'(DIV_RESET);
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
        end
    end

    assign tick_o = tick_q;
    assign busy_o = (state_q == S_RUN);

endmodule

// File: tb/tb_tick_prescaler.sv
// Bench for tick_prescaler: behavioural "cycles remaining" model checked
// against tick_o/busy_o every cycle, directed scenarios with literal pins,
// then randomized stimulus.
module tb_tick_prescaler;

    localparam int WIDTH     = 8;
    localparam int DIV_RESET = 0;

    logic             clk = 1'b0;
    logic             rst_i = 1'b0;
    logic [WIDTH-1:0] div_i = '0;
    logic             load_i = 1'b0;
    logic             start_i = 1'b0;
    logic             stop_i = 1'b0;
    logic             oneshot_i = 1'b0;
    logic             gate_i = 1'b1;
    logic             tick_o;
    logic             busy_o;

    tick_prescaler #(.WIDTH(WIDTH), .DIV_RESET(DIV_RESET)) dut (
        .clk_i(clk), .rst_i(rst_i), .div_i(div_i), .load_i(load_i),
        .start_i(start_i), .stop_i(stop_i), .oneshot_i(oneshot_i),
        .gate_i(gate_i), .tick_o(tick_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: running flag, one-shot flag, divider, enabled cycles left until tick
    bit m_run, m_one;
    int m_div, m_rem;
    bit g1, g2;          // gate seen one and two edges ago
    bit exp_tick, exp_busy;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic model_update();
        bit en;
        if (rst_i) begin
            m_run = 0; m_one = 0; m_div = DIV_RESET; m_rem = 0;
            g1 = 0; g2 = 0; exp_tick = 0;
        end else begin
`ifdef TICK_PRESCALER_GATE_EN
            en = g2;
`else
            en = 1'b1;
`endif
            g2 = g1;
            g1 = gate_i;
            exp_tick = 0;
            if (load_i) begin
                m_div = int'(div_i);
                m_rem = m_div + 1;
            end else if (!m_run) begin
                if (start_i && !stop_i) begin
                    m_run = 1; m_one = oneshot_i; m_rem = m_div + 1;
                end
            end else if (stop_i) begin
                m_run = 0;
            end else if (en) begin
                m_rem--;
                if (m_rem == 0) begin
                    exp_tick = 1;
                    m_rem = m_div + 1;
                    if (m_one) m_run = 0;
                end
            end
        end
        exp_busy = m_run;
    endtask

    // One clock: model advances on the edge, DUT compared on the falling edge
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check("tick_o", {31'd0, tick_o}, {31'd0, exp_tick});
        check("busy_o", {31'd0, busy_o}, {31'd0, exp_busy});
        rst_i = 0; load_i = 0; start_i = 0; stop_i = 0;
    endtask

    task automatic run(input int n, output int nt, output int first, output bit busy_first);
        nt = 0; first = -1; busy_first = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (exp_tick) begin
                if (first < 0) begin
                    first = i + 1;
                    busy_first = exp_busy;
                end
                nt++;
            end
        end
    endtask

    task automatic do_load(input int d);
        div_i = WIDTH'(d); load_i = 1; step();
    endtask

    task automatic do_start(input bit one);
        oneshot_i = one; start_i = 1; step();
    endtask

    task automatic do_stop();
        stop_i = 1; step();
    endtask

    initial begin
        int nt, first;
        bit bf;

        // Reset
        @(negedge clk);
        rst_i = 1; step();
        rst_i = 1; step();
        check("reset_tick", {31'd0, exp_tick}, 32'd0);
        check("reset_busy", {31'd0, exp_busy}, 32'd0);

        // Continuous, div=3
        do_load(3);
        do_start(0);
        check("start_busy", {31'd0, exp_busy}, 32'd1);
        run(20, nt, first, bf);
        check("div3_first", first, 32'd4);
        check("div3_ticks", nt, 32'd5);

        // div=0: tick every cycle
        do_stop();
        do_load(0);
        do_start(0);
        run(10, nt, first, bf);
        check("div0_ticks", nt, 32'd10);

        // One-shot, div=2
        do_stop();
        do_load(2);
        do_start(1);
        run(20, nt, first, bf);
        check("oneshot_ticks", nt, 32'd1);
        check("oneshot_first", first, 32'd3);
        check("oneshot_busy_at_tick", {31'd0, bf}, 32'd0);

        // Stop on the edge that would tick
        do_load(5);
        do_start(0);
        run(5, nt, first, bf);
        check("pre_stop_ticks", nt, 32'd0);
        do_stop();
        check("stop_tick", {31'd0, exp_tick}, 32'd0);
        check("stop_busy", {31'd0, exp_busy}, 32'd0);
        start_i = 1; stop_i = 1; step();
        check("start_stop_busy", {31'd0, exp_busy}, 32'd0);

        // Reload mid-period, then reset mid-period
        do_load(7);
        do_start(0);
        run(4, nt, first, bf);
        do_load(1);
        run(4, nt, first, bf);
        check("reload_first", first, 32'd2);
        check("reload_ticks", nt, 32'd2);
        run(1, nt, first, bf);
        rst_i = 1; step();
        check("rst_mid_tick", {31'd0, exp_tick}, 32'd0);
        check("rst_mid_busy", {31'd0, exp_busy}, 32'd0);
        do_start(0);
        run(6, nt, first, bf);
`ifdef TICK_PRESCALER_GATE_EN
        check("div_reset_ticks", nt, 32'd5);
`else
        check("div_reset_ticks", nt, 32'd6);
`endif

        // Gate low for 6 cycles mid-run, div=1
        do_stop();
        do_load(1);
        do_start(0);
        nt = 0;
        for (int i = 0; i < 26; i++) begin
            gate_i = !(i >= 10 && i < 16);
            step();
            if (exp_tick) nt++;
        end
        gate_i = 1;
`ifdef TICK_PRESCALER_GATE_EN
        check("gate_ticks", nt, 32'd10);
`else
        check("gate_ticks", nt, 32'd13);
`endif

        // Randomized stimulus
        for (int i = 0; i < 2000; i++) begin
            rst_i     = ($urandom_range(0, 199) == 0);
            load_i    = ($urandom_range(0, 29) == 0);
            div_i     = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 6));
            start_i   = ($urandom_range(0, 7) == 0);
            stop_i    = ($urandom_range(0, 39) == 0);
            oneshot_i = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0) gate_i = ~gate_i;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
